// File: rtl/vec_mem_pkg.sv
// ---------------------------------------------------------------------------
// vec_mem_pkg
//   Shared types and constants for the vector memory responder.
//   - state_e       : responder FSM states
//   - bus_id_t      : requester bus ID {core_id, component_type}
//   - createBusID   : builds a bus_id_t from its two fields
//   - POINTER_SIZE  : bytes per backing-array word (byte address -> word index)
//   - NUM_LANES_DEFAULT : default lanes per vector request
//   - sat_inc32     : saturating 32-bit increment used by the statistics counters
// ---------------------------------------------------------------------------
package vec_mem_pkg;

    localparam int POINTER_SIZE      = 8;
    localparam int NUM_LANES_DEFAULT = 8;

    localparam int CORE_ID_W   = 4;
    localparam int COMP_TYPE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [CORE_ID_W-1:0]   core_id;
        logic [COMP_TYPE_W-1:0] component_type;
    } bus_id_t;

    function automatic bus_id_t createBusID(
        input logic [CORE_ID_W-1:0]   core_id,
        input logic [COMP_TYPE_W-1:0] component_type
    );
        bus_id_t id;
        id.core_id        = core_id;
        id.component_type = component_type;
        return id;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/vec_mem_array.sv
// ---------------------------------------------------------------------------
// vec_mem_array
//   Single-port MEM_WORDS x DATA_W backing store for the vector responder.
//   Read is combinational from the same index that a write uses; a write is
//   committed on the rising edge, so it becomes visible to reads afterwards.
//   The array has no reset: contents survive a responder reset.
// Ports:
//   clk    in  clock
//   we     in  write enable for this edge
//   addr   in  word index
//   wdata  in  write data
//   rdata  out word currently stored at addr
// ---------------------------------------------------------------------------
module vec_mem_array #(
    parameter int  MEM_WORDS = 1024,
    parameter int  DATA_W    = 64,
    localparam int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/vec_memory_responder.sv
// ---------------------------------------------------------------------------
// vec_memory_responder
//   Memory-side responder for the vector memory bus. A request (one byte
//   address per lane, plus per-lane data for writes) is latched in IDLE, then
//   served one lane per cycle in ACCESS against a word-addressed array.
//   Reads finish in RESP, holding one response packet tagged with the
//   requester's bus ID until it is accepted. Writes complete silently.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   request_valid       initiator presents a request (sampled in IDLE only)
//   request_is_write    1 = write, 0 = read
//   request_addr        per-lane byte addresses, lane 0 in LSBs
//   request_data        per-lane write data, lane 0 in LSBs
//   request_source      requester bus ID
//   request_ready       responder is in IDLE and out of reset
//   response_busy       read response held and available
//   response_payload    read data, lane 0 in LSBs
//   response_dest_id    request_source of the read being answered
//   response_accept     initiator consumes the held response
//   oob_error           sticky: some lane addressed past the array
//
// Optional feature (macro VEC_MEM_RESPONDER_STATS_EN):
//   stat_reads, stat_writes, stat_resp_stall -- saturating 32-bit counters of
//   accepted reads, accepted writes and RESP cycles without response_accept.
// ---------------------------------------------------------------------------
module vec_memory_responder
    import vec_mem_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEFAULT,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int MEM_WORDS = 1024,
    parameter int BUS_ID_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        request_valid,
    input  logic                        request_is_write,
    input  logic [NUM_LANES*ADDR_W-1:0] request_addr,
    input  logic [NUM_LANES*DATA_W-1:0] request_data,
    input  logic [BUS_ID_W-1:0]         request_source,
    output logic                        request_ready,
    output logic                        response_busy,
    output logic [NUM_LANES*DATA_W-1:0] response_payload,
    output logic [BUS_ID_W-1:0]         response_dest_id,
    input  logic                        response_accept,
    output logic                        oob_error
`ifdef VEC_MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]                 stat_reads,
    output logic [31:0]                 stat_writes,
    output logic [31:0]                 stat_resp_stall
`endif
);

    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int IDX_W     = $clog2(MEM_WORDS);
    localparam int PTR_SHIFT = $clog2(POINTER_SIZE);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    // -----------------------------------------------------------------------
    // Per-lane views of the flat request/response buses
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] req_addr_lane [NUM_LANES];
    logic [DATA_W-1:0] req_data_lane [NUM_LANES];

    logic [ADDR_W-1:0] addr_q    [NUM_LANES];
    logic [ADDR_W-1:0] addr_d    [NUM_LANES];
    logic [DATA_W-1:0] wdata_q   [NUM_LANES];
    logic [DATA_W-1:0] wdata_d   [NUM_LANES];
    logic [DATA_W-1:0] payload_q [NUM_LANES];
    logic [DATA_W-1:0] payload_d [NUM_LANES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign req_addr_lane[gi] = request_addr[gi*ADDR_W +: ADDR_W];
            assign req_data_lane[gi] = request_data[gi*DATA_W +: DATA_W];
            assign response_payload[gi*DATA_W +: DATA_W] = payload_q[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                is_write_q, is_write_d;
    logic [BUS_ID_W-1:0] dest_q, dest_d;
    logic                oob_q, oob_d;
    logic                load_req;

    // -----------------------------------------------------------------------
    // Current lane and the backing array
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_in_range;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;

    assign cur_addr  = addr_q[lane_q];
    assign cur_wdata = wdata_q[lane_q];
    // In range iff addr < MEM_WORDS*POINTER_SIZE, i.e. no bits set above the
    // word index field. Byte-offset bits below the index are ignored.
    assign cur_in_range = ((cur_addr >> (PTR_SHIFT + IDX_W)) == '0);
    assign mem_idx      = cur_addr[PTR_SHIFT +: IDX_W];
    // Gated by reset_n so a lane that coincides with a reset edge is dropped.
    assign mem_we       = reset_n && (state_q == ACCESS) && is_write_q && cur_in_range;

    vec_mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .DATA_W    (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_idx),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        is_write_d = is_write_q;
        dest_d     = dest_q;
        oob_d      = oob_q;
        payload_d  = payload_q;
        load_req   = 1'b0;

        case (state_q)
            IDLE: begin
                if (request_valid) begin
                    load_req   = 1'b1;
                    is_write_d = request_is_write;
                    lane_d     = '0;
                    state_d    = ACCESS;
                    // Only reads produce a response, so only reads retag it.
                    if (!request_is_write) begin
                        dest_d = request_source;
                    end
                end
            end

            ACCESS: begin
                if (!cur_in_range) begin
                    oob_d = 1'b1;
                end
                if (!is_write_q) begin
                    payload_d[lane_q] = cur_in_range ? mem_rdata : '0;
                end
                if (lane_q == LAST_LANE) begin
                    state_d = is_write_q ? IDLE : RESP;
                end else begin
                    lane_d = lane_q + LANE_W'(1);
                end
            end

            RESP: begin
                if (response_accept) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (load_req) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                addr_d[i]  = req_addr_lane[i];
                wdata_d[i] = req_data_lane[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            is_write_q <= 1'b0;
            dest_q     <= '0;
            oob_q      <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                payload_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            is_write_q <= is_write_d;
            dest_q     <= dest_d;
            oob_q      <= oob_d;
            payload_q  <= payload_d;
        end
    end

    // Latched request address/data only matter after a load, so they carry
    // no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign request_ready    = reset_n && (state_q == IDLE);
    assign response_busy    = (state_q == RESP);
    assign response_dest_id = dest_q;
    assign oob_error        = oob_q;

`ifdef VEC_MEM_RESPONDER_STATS_EN
    // -----------------------------------------------------------------------
    // Statistics counters
    // -----------------------------------------------------------------------
    logic [31:0] stat_reads_q, stat_reads_d;
    logic [31:0] stat_writes_q, stat_writes_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_reads_d  = stat_reads_q;
        stat_writes_d = stat_writes_q;
        stat_stall_d  = stat_stall_q;
        if (load_req) begin
            if (request_is_write) begin
                stat_writes_d = sat_inc32(stat_writes_q);
            end else begin
                stat_reads_d = sat_inc32(stat_reads_q);
            end
        end
        if ((state_q == RESP) && !response_accept) begin
            stat_stall_d = sat_inc32(stat_stall_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_reads_q  <= stat_reads_d;
            stat_writes_q <= stat_writes_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_reads      = stat_reads_q;
    assign stat_writes     = stat_writes_q;
    assign stat_resp_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_vec_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_vec_memory_responder
//   Self-checking bench: a memory model predicts read payloads when a read is
//   issued; the prediction is queued and compared when response_busy rises.
// ---------------------------------------------------------------------------
module tb_vec_memory_responder;
    import vec_mem_pkg::*;

    localparam int NL  = 8;
    localparam int DW  = 64;
    localparam int AW  = 64;
    localparam int MW  = 1024;
    localparam int BW  = 8;
    localparam int MAW = $clog2(MW);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              request_valid;
    logic              request_is_write;
    logic [NL*AW-1:0]  request_addr;
    logic [NL*DW-1:0]  request_data;
    logic [BW-1:0]     request_source;
    logic              request_ready;
    logic              response_busy;
    logic [NL*DW-1:0]  response_payload;
    logic [BW-1:0]     response_dest_id;
    logic              response_accept;
    logic              oob_error;
`ifdef VEC_MEM_RESPONDER_STATS_EN
    logic [31:0]       stat_reads;
    logic [31:0]       stat_writes;
    logic [31:0]       stat_resp_stall;
`endif

    always #5 clk = ~clk;

    vec_memory_responder #(
        .NUM_LANES (NL),
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .MEM_WORDS (MW),
        .BUS_ID_W  (BW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .request_valid    (request_valid),
        .request_is_write (request_is_write),
        .request_addr     (request_addr),
        .request_data     (request_data),
        .request_source   (request_source),
        .request_ready    (request_ready),
        .response_busy    (response_busy),
        .response_payload (response_payload),
        .response_dest_id (response_dest_id),
        .response_accept  (response_accept),
        .oob_error        (oob_error)
`ifdef VEC_MEM_RESPONDER_STATS_EN
        ,
        .stat_reads       (stat_reads),
        .stat_writes      (stat_writes),
        .stat_resp_stall  (stat_resp_stall)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NL*DW-1:0] payload;
        logic [BW-1:0]    dest;
    } exp_t;

    exp_t        sb_q[$];
    logic [DW-1:0] model_mem [MW];
    logic [AW-1:0] lane_addr [NL];
    logic [DW-1:0] lane_data [NL];

    function automatic logic in_range(input logic [AW-1:0] a);
        return a < 64'(MW * 8);
    endfunction

    function automatic int word_of(input logic [AW-1:0] a);
        return int'(a[3 +: MAW]);
    endfunction

    task automatic drive_req(input logic is_write, input logic [BW-1:0] src);
        request_valid    = 1'b1;
        request_is_write = is_write;
        request_source   = src;
        for (int i = 0; i < NL; i++) begin
            request_addr[i*AW +: AW] = lane_addr[i];
            request_data[i*DW +: DW] = lane_data[i];
        end
    endtask

    task automatic issue_write(input logic [BW-1:0] src, input string name);
        @(negedge clk);
        checks++;
        if (request_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_before got %b exp 1", name, request_ready);
        end
        for (int i = 0; i < NL; i++) begin
            if (in_range(lane_addr[i])) model_mem[word_of(lane_addr[i])] = lane_data[i];
        end
        drive_req(1'b1, src);
        @(posedge clk); #1;
        request_valid = 1'b0;
        repeat (NL - 1) @(posedge clk);
        #1;
        checks++;
        if (request_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_lane7 ready got %b exp 0", name, request_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (request_ready !== 1'b1 || response_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done ready/busy got %b/%b exp 1/0", name, request_ready, response_busy);
        end
        $display("WRITE %s src=%h lane0_addr=%h lane0_data=%h", name, src, lane_addr[0], lane_data[0]);
    endtask

    task automatic issue_read(input logic [BW-1:0] src, input int stall, input bit inject, input string name);
        exp_t e;
        int   n;
        @(negedge clk);
        checks++;
        if (request_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_before got %b exp 1", name, request_ready);
        end
        e.dest = src;
        for (int i = 0; i < NL; i++) begin
            e.payload[i*DW +: DW] = in_range(lane_addr[i]) ? model_mem[word_of(lane_addr[i])] : '0;
        end
        sb_q.push_back(e);
        drive_req(1'b0, src);
        @(posedge clk); #1;
        request_valid = 1'b0;
        n = 0;
        while (response_busy !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != NL) begin
            errors++;
            $display("FAIL %s_latency got %0d edges exp %0d", name, n, NL);
        end
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard_empty got 0 entries exp 1", name);
            return;
        end
        e = sb_q.pop_front();
        checks++;
        if (response_payload !== e.payload) begin
            errors++;
            $display("FAIL %s_payload got %h exp %h", name, response_payload, e.payload);
        end
        checks++;
        if (response_dest_id !== e.dest) begin
            errors++;
            $display("FAIL %s_dest got %h exp %h", name, response_dest_id, e.dest);
        end
        for (int k = 0; k < stall; k++) begin
            if (inject && k == 0) begin
                // Bogus write presented while busy; must be ignored.
                for (int i = 0; i < NL; i++) begin
                    lane_addr[i] = '0;
                    lane_data[i] = 64'hDEAD_0000 + 64'(i);
                end
                drive_req(1'b1, 8'hEE);
            end
            checks++;
            if (response_payload !== e.payload || response_dest_id !== e.dest ||
                request_ready !== 1'b0 || response_busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_stall%0d payload/dest/ready/busy got %h/%h/%b/%b exp %h/%h/0/1",
                         name, k, response_payload, response_dest_id, request_ready,
                         response_busy, e.payload, e.dest);
            end
            @(posedge clk); #1;
        end
        request_valid   = 1'b0;
        response_accept = 1'b1;
        @(posedge clk); #1;
        response_accept = 1'b0;
        checks++;
        if (response_busy !== 1'b0 || request_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after_accept busy/ready got %b/%b exp 0/1", name, response_busy, request_ready);
        end
        $display("READ %s src=%h stall=%0d lane0=%h lane7=%h", name, src, stall,
                 response_payload[0 +: DW], response_payload[7*DW +: DW]);
    endtask

    task automatic test_reset();
        reset_n          = 1'b0;
        request_valid    = 1'b0;
        request_is_write = 1'b0;
        request_addr     = '0;
        request_data     = '0;
        request_source   = '0;
        response_accept  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (request_ready !== 1'b0 || response_busy !== 1'b0 || response_payload !== '0 ||
            response_dest_id !== '0 || oob_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_values ready/busy/payload/dest/oob got %b/%b/%h/%h/%b exp 0/0/0/0/0",
                     request_ready, response_busy, response_payload, response_dest_id, oob_error);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (request_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b exp 1", request_ready);
        end
        $display("RESET done");
    endtask

    task automatic test_write_read();
        for (int i = 0; i < NL; i++) begin
            lane_addr[i] = 64'(8 * i);
            lane_data[i] = 64'h100 + 64'(i);
        end
        issue_write(8'h11, "wr_basic");
        issue_read(createBusID(4'h2, 4'h3), 0, 1'b0, "rd_basic");
    endtask

    task automatic test_duplicate_write();
        for (int i = 0; i < NL; i++) begin
            lane_addr[i] = 64'h40;
            lane_data[i] = 64'(i);
        end
        issue_write(8'h12, "wr_dup");
        issue_read(8'h34, 0, 1'b0, "rd_dup");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < NL; i++) lane_addr[i] = 64'(8 * i);
        issue_read(8'h55, 5, 1'b1, "rd_backpressure");
        // Confirm the write injected while busy left the array untouched.
        for (int i = 0; i < NL; i++) lane_addr[i] = 64'(8 * i);
        issue_read(8'h56, 0, 1'b0, "rd_after_bogus");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NL; i++) begin
            lane_addr[i] = 64'h80 + 64'(8 * i);
            lane_data[i] = 64'hC0 + 64'(i);
        end
        issue_write(8'h21, "wr_b2b_a");
        for (int i = 0; i < NL; i++) begin
            lane_addr[i] = 64'hC0 + 64'(8 * i);
            lane_data[i] = 64'hF00 + 64'(i * 3);
        end
        issue_write(8'h22, "wr_b2b_b");
        // Low three address bits are ignored by the responder.
        for (int i = 0; i < NL; i++) begin
            lane_addr[i] = (i < 4) ? 64'h80 + 64'(8 * i) + 64'd3 : 64'hC0 + 64'(8 * (i - 4)) + 64'd5;
        end
        issue_read(8'h77, 0, 1'b0, "rd_b2b");
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        checks++;
        if (oob_error !== 1'b0) begin
            errors++;
            $display("FAIL oob_before got %b exp 0", oob_error);
        end
        for (int i = 0; i < NL; i++) lane_addr[i] = 64'(8 * i);
        lane_addr[3] = 64'(MW * 8);
        issue_read(8'h66, 0, 1'b0, "rd_oob");
        checks++;
        if (oob_error !== 1'b1) begin
            errors++;
            $display("FAIL oob_set got %b exp 1", oob_error);
        end
        for (int i = 0; i < NL; i++) begin
            lane_addr[i] = 64'h200 + 64'(8 * i);
            lane_data[i] = 64'h5000 + 64'(i);
        end
        issue_write(8'h67, "wr_inrange_after_oob");
        checks++;
        if (oob_error !== 1'b1) begin
            errors++;
            $display("FAIL oob_sticky got %b exp 1", oob_error);
        end
    endtask

    task automatic test_reset_mid_op();
        for (int i = 0; i < NL; i++) begin
            lane_addr[i] = 64'h400 + 64'(8 * i);
            lane_data[i] = 64'hAAAA_0000 + 64'(i);
        end
        issue_write(8'h31, "wr_prefill");
        for (int i = 0; i < NL; i++) lane_data[i] = 64'hBBBB_0000 + 64'(i);
        @(negedge clk);
        drive_req(1'b1, 8'h32);
        @(posedge clk); #1;
        request_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) model_mem[word_of(lane_addr[i])] = lane_data[i];
        reset_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (request_ready !== 1'b0 || response_busy !== 1'b0 || response_payload !== '0 ||
            response_dest_id !== '0 || oob_error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values ready/busy/payload/dest/oob got %b/%b/%h/%h/%b exp 0/0/0/0/0",
                     request_ready, response_busy, response_payload, response_dest_id, oob_error);
        end
        reset_n = 1'b1;
        $display("RESET mid-write at lane 4");
        issue_read(8'h33, 0, 1'b0, "rd_after_midreset");
    endtask

`ifdef VEC_MEM_RESPONDER_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks++;
        if (stat_reads !== 32'd0 || stat_writes !== 32'd0 || stat_resp_stall !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset got %0d/%0d/%0d exp 0/0/0", stat_reads, stat_writes, stat_resp_stall);
        end
        for (int i = 0; i < NL; i++) lane_addr[i] = 64'(8 * i);
        issue_read(8'h41, 3, 1'b0, "rd_stats_a");
        for (int i = 0; i < NL; i++) lane_addr[i] = 64'(8 * i);
        issue_read(8'h42, 0, 1'b0, "rd_stats_b");
        for (int i = 0; i < NL; i++) begin
            lane_addr[i] = 64'h600 + 64'(8 * i);
            lane_data[i] = 64'h9000 + 64'(i);
        end
        issue_write(8'h43, "wr_stats");
        checks++;
        if (stat_reads !== 32'd2 || stat_writes !== 32'd1 || stat_resp_stall !== 32'd3) begin
            errors++;
            $display("FAIL stats_counts got %0d/%0d/%0d exp 2/1/3", stat_reads, stat_writes, stat_resp_stall);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_duplicate_write();
        test_backpressure();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_op();
`ifdef VEC_MEM_RESPONDER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_memory_responder.md
# vec_memory_responder

- **Role:** Memory-side responder for the vector memory bus. The store stage and other vector bus initiators issue vector read and write requests to it.
- **Request format:** Each request carries one 64-bit byte address per lane, plus per-lane write data for writes.
- **Service:** Lanes are served one per cycle against a word-addressed backing array.
- **Responses:** Reads return a single vector response packet tagged with the requester's bus ID. Writes complete silently, with no response.

## Interface
Parameters:
- NUM_LANES, 8, lanes per vector request
- DATA_W, 64, lane data width
- ADDR_W, 64, lane byte-address width
- MEM_WORDS, 1024, backing array depth in DATA_W words (power of two)
- BUS_ID_W, 8, width of requester bus ID

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- request_valid  in  1  initiator presents a request
- request_is_write  in  1  1 = write, 0 = read
- request_addr  in  NUM_LANES*ADDR_W  per-lane byte addresses, lane 0 in LSBs
- request_data  in  NUM_LANES*DATA_W  per-lane write data
- request_source  in  BUS_ID_W  requester bus ID
- request_ready  out  1  responder can accept a request this cycle
- response_busy  out  1  read response held and available
- response_payload  out  NUM_LANES*DATA_W  read data, lane 0 in LSBs
- response_dest_id  out  BUS_ID_W  copy of the request_source of the read
- response_accept  in  1  initiator consumes the held response
- oob_error  out  1  sticky flag for any out-of-range lane address

## Operation
- **States:** IDLE, ACCESS, RESP.
- **IDLE:**
  - request_ready = 1 whenever reset_n = 1.
  - On an edge with request_valid=1: latch addr, data, is_write and source; clear lane counter; go to ACCESS.
- **ACCESS:** one lane per edge, in order lane 0 .. NUM_LANES-1.
  - Word index = addr[3 +: log2(MEM_WORDS)]. addr[2:0] is ignored; POINTER_SIZE is 8.
  - A lane is in range only if addr < MEM_WORDS*8.
  - Read lane in range: the array word goes into payload[lane].
  - Read lane out of range: payload[lane] = 0 and oob_error is set.
  - Write lane in range: the array word is written.
  - Write lane out of range: the write is dropped and oob_error is set.
  - On the edge that processes lane NUM_LANES-1, a read goes to RESP and a write goes to IDLE.
- **RESP:**
  - response_busy = 1; payload and dest_id are held stable.
  - response_accept=1 on an edge returns the block to IDLE.
- **Lane ordering:**
  - Duplicate write addresses within one request: the highest lane wins.
  - A read lane sees writes from all earlier requests.
- **Ignored inputs:**
  - response_accept while response_busy=0 is ignored.
  - request_valid outside IDLE is ignored. The initiator must hold the request until the block returns to IDLE.
- **Reset values:** request_ready=0, response_busy=0, response_payload=0, response_dest_id=0, oob_error=0, state=IDLE, lane counter=0.
- **Reset mid-operation:** the in-flight request is discarded. Array writes already performed are retained. The array is never cleared by reset.

## Timing
- **Acceptance:** request accepted at edge E0.
- **Lane processing:** lane i is processed at edge E(i+1).
- **Read latency:** response_busy rises after edge E(NUM_LANES), i.e. E8 for defaults.
- **Read turnaround:** with response_accept tied high, the response is consumed at E(NUM_LANES+1). request_ready is high again in the following cycle.
- **Write completion:** after edge E(NUM_LANES) the block is back in IDLE. A back-to-back request can be accepted at E(NUM_LANES+1).
- **Throughput:** one request outstanding at a time; no pipelining across requests.
- **Array behaviour:** combinational read, synchronous write. A write at edge Ek is visible to reads processed at edges after Ek.

## Configuration
- **Macro:** VEC_MEM_RESPONDER_STATS_EN.
- **When defined:** three additional 32-bit outputs exist. All reset to 0 and saturate at 2^32-1.
  - stat_reads counts accepted reads.
  - stat_writes counts accepted writes.
  - stat_resp_stall counts cycles in RESP with response_accept=0.
- **When undefined:** these ports and counters are absent, and behaviour is otherwise identical.

## Structure
- **Package vec_mem_pkg:**
  - state enum {IDLE, ACCESS, RESP}
  - bus ID type (core_id, component_type), plus createBusID
  - POINTER_SIZE = 8
  - lane count default
- **Sub-module vec_mem_array:** single-port MEM_WORDS x DATA_W array with combinational read and synchronous write enable. The FSM, latches and flags stay in the top module.

## Test plan
- **Write then read:** write lanes addr 0,8,..,56 with data 0x100+lane, then read the same addresses. Expect response_busy after 8 edges, payload lane i = 0x100+i, and dest_id equal to the source used (e.g. 0x23).
- **Duplicate write lanes:** all 8 lanes write addr 0x40 with data = lane index, then read addr 0x40. Expect 7 in every lane.
- **Backpressure:** hold response_accept=0 for 5 cycles after response_busy rises. Expect payload and dest_id stable, request_ready=0, and a new request_valid ignored. Accept, then request_ready=1 the next cycle.
- **Out of range:** read with lane 3 addr = MEM_WORDS*8. Expect lane 3 = 0, other lanes correct, and oob_error=1 until reset.
- **Reset mid-operation:** assert reset_n=0 at lane 4 of a write. Expect all outputs at reset values, lanes 0–3 written, lanes 4–7 unchanged on a later read.
- **Stats (macro defined):** issue 2 reads and 1 write with 3 stall cycles. Expect stat_reads=2, stat_writes=1, stat_resp_stall=3.
